// File: rtl/ballot_station.sv
// ballot_station
//
// Voter-side front end for an 8-candidate tally counter. An election is opened
// with `start`, which also fires a one-cycle `tally_rst` enable pulse to the
// tally. Each voter then casts a selection, which is held in `pending`. The
// voter confirms or cancels it; if the voter does neither within TIMEOUT
// cycles, the selection is discarded. A confirmed ballot is sent on `data` as
// a one-hot word for exactly one cycle, followed by GAP_CYCLES idle cycles.
// After MAX_VOTES ballots the station parks in DONE until the next `start`.
//
// Parameters
//   MAX_VOTES   ballots per election (legal range 1..15)
//   TIMEOUT     CONFIRM cycles allowed before a selection expires (>= 2)
//   GAP_CYCLES  idle cycles forced after each transmitted ballot (>= 1)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   start       open an election (honoured in IDLE or DONE only)
//   sel[2:0]    candidate index, sampled together with cast
//   cast        selection strobe (accepted in ARMED only)
//   confirm     commit the pending selection
//   cancel      discard the pending selection (wins over confirm)
//   tally_rst   one-cycle enable pulse to the tally
//   data[7:0]   one-hot ballot for one cycle, otherwise 0
//   pending[7:0] latched one-hot selection, 0 when none is pending
//   votes_sent[3:0] ballots transmitted in this election
//   busy        high in every state except IDLE and DONE
//   timeout     one-cycle pulse when a pending selection expires
//   done        high in DONE
//
// Every output is a register driven from the single state-machine process.

module ballot_station #(
  parameter int MAX_VOTES  = 9,
  parameter int TIMEOUT    = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] sel,
  input  logic       cast,
  input  logic       confirm,
  input  logic       cancel,
  output logic       tally_rst,
  output logic [7:0] data,
  output logic [7:0] pending,
  output logic [3:0] votes_sent,
  output logic       busy,
  output logic       timeout,
  output logic       done
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CONFIRM,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;    // CONFIRM cycles elapsed without a decision
  logic [GW-1:0]   gap_cnt;  // idle cycles elapsed in GAP

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      gap_cnt    <= '0;
      tally_rst  <= 1'b0;
      data       <= '0;
      pending    <= '0;
      votes_sent <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: the pulse outputs are defaulted low here and raised only by the
      // branch that needs them; non-blocking assignment lets a later branch
      // override the default within the same edge.
      tally_rst <= 1'b0;
      timeout   <= 1'b0;
      data      <= '0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_ARMED;
            tally_rst  <= 1'b1;
            votes_sent <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
          end
        end

        S_ARMED: begin
          if (cast) begin
            pending <= 8'd1 << sel;
            timer   <= '0;
            state   <= S_CONFIRM;
          end
        end

        S_CONFIRM: begin
          // A voter decision takes priority over expiry on the same edge.
          if (cancel) begin
            pending <= '0;
            state   <= S_ARMED;
          end else if (confirm) begin
            data       <= pending;
            votes_sent <= votes_sent + 4'd1;
            state      <= S_SEND;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            pending <= '0;
            timeout <= 1'b1;
            state   <= S_ARMED;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_SEND: begin
          // data drops back to 0 through the default above.
          pending <= '0;
          if (votes_sent == 4'(MAX_VOTES)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= S_ARMED;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_station.sv
// Directed bench for ballot_station with the default parameters
// (MAX_VOTES=9, TIMEOUT=16, GAP_CYCLES=2).
// Inputs change 1 ns after a rising edge, and outputs are sampled at that
// same point. The value observed after a tick is therefore the state set
// up by that edge. All outputs are packed into a single 24-bit observation
// word, laid out as {tally_rst, data, pending, votes_sent, busy, timeout, done}.

module tb_ballot_station;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] sel = '0;
  logic       cast = 1'b0;
  logic       confirm = 1'b0;
  logic       cancel = 1'b0;
  logic       tally_rst;
  logic [7:0] data;
  logic [7:0] pending;
  logic [3:0] votes_sent;
  logic       busy;
  logic       timeout;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] obs;
  logic [23:0] expv;

  assign obs = {tally_rst, data, pending, votes_sent, busy, timeout, done};

  ballot_station #(
    .MAX_VOTES (9),
    .TIMEOUT   (16),
    .GAP_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel       (sel),
    .cast      (cast),
    .confirm   (confirm),
    .cancel    (cancel),
    .tally_rst (tally_rst),
    .data      (data),
    .pending   (pending),
    .votes_sent(votes_sent),
    .busy      (busy),
    .timeout   (timeout),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    expv = 24'h0;
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL reset_state: got %h want %h", obs, expv); end
    rst = 1'b1;
  endtask

  task automatic test_arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    expv = {1'b1, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL arm_pulse: got %h want %h", obs, expv); end
    tick();
    expv = {1'b0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL arm_pulse_drop: got %h want %h", obs, expv); end
  endtask

  task automatic test_single_ballot();
    sel = 3'd3; cast = 1'b1;
    tick();
    cast = 1'b0;
    expv = {1'b0, 8'h00, 8'h08, 4'd0, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL single_pending: got %h want %h", obs, expv); end
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    expv = {1'b0, 8'h08, 8'h08, 4'd1, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL single_data: got %h want %h", obs, expv); end
    tick();
    expv = {1'b0, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL single_data_drop: got %h want %h", obs, expv); end
    // Two GAP edges: a cast here must be ignored.
    sel = 3'd6; cast = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL gap_cast_ignored[%0d]: got %h want %h", k, obs, expv); end
    end
    cast = 1'b0;
  endtask

  task automatic test_cancel_priority();
    sel = 3'd5; cast = 1'b1;
    tick();
    cast = 1'b0;
    expv = {1'b0, 8'h00, 8'h20, 4'd1, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL cancel_pending: got %h want %h", obs, expv); end
    confirm = 1'b1; cancel = 1'b1;
    tick();
    cancel = 1'b0;
    expv = {1'b0, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL cancel_wins: got %h want %h", obs, expv); end
    // Back in ARMED: confirm alone does nothing.
    tick();
    confirm = 1'b0;
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL armed_confirm_ignored: got %h want %h", obs, expv); end
    sel = 3'd0; cast = 1'b1;
    tick();
    cast = 1'b0; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    expv = {1'b0, 8'h01, 8'h01, 4'd2, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL recast_data: got %h want %h", obs, expv); end
    tick();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    // start while ARMED is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    expv = {1'b0, 8'h00, 8'h00, 4'd2, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL start_ignored: got %h want %h", obs, expv); end
    sel = 3'd7; cast = 1'b1;
    tick();
    cast = 1'b0;
    expv = {1'b0, 8'h00, 8'h80, 4'd2, 1'b1, 1'b0, 1'b0};
    for (int k = 1; k < 16; k++) begin
      tick();
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL timeout_wait[%0d]: got %h want %h", k, obs, expv); end
    end
    tick();
    expv = {1'b0, 8'h00, 8'h00, 4'd2, 1'b1, 1'b1, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL timeout_pulse: got %h want %h", obs, expv); end
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    expv = {1'b0, 8'h00, 8'h00, 4'd2, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL timeout_late_confirm: got %h want %h", obs, expv); end
  endtask

  task automatic test_full_election();
    logic [2:0] sels  [9] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd1, 3'd5};
    logic [7:0] words [9] = '{8'h01, 8'h02, 8'h02, 8'h04, 8'h02, 8'h08, 8'h10, 8'h02, 8'h20};
    rst = 1'b0;
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    expv = {1'b1, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL election_arm: got %h want %h", obs, expv); end
    for (int i = 0; i < 9; i++) begin
      sel = sels[i]; cast = 1'b1;
      tick();
      cast = 1'b0; confirm = 1'b1;
      tick();
      confirm = 1'b0;
      expv = {1'b0, words[i], words[i], 4'(i + 1), 1'b1, 1'b0, 1'b0};
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL ballot[%0d]: got %h want %h", i, obs, expv); end
      tick();
      if (i < 8) begin
        expv = {1'b0, 8'h00, 8'h00, 4'(i + 1), 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs !== expv) begin miscompares++; $display("FAIL ballot_gap[%0d]: got %h want %h", i, obs, expv); end
        tick();
        tick();
      end
    end
    expv = {1'b0, 8'h00, 8'h00, 4'd9, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL election_done: got %h want %h", obs, expv); end
    sel = 3'd2; cast = 1'b1;
    tick();
    cast = 1'b0; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL done_extra_ballot: got %h want %h", obs, expv); end
    start = 1'b1;
    tick();
    start = 1'b0;
    expv = {1'b1, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL rearm: got %h want %h", obs, expv); end
  endtask

  task automatic test_reset_mid_send();
    sel = 3'd4; cast = 1'b1;
    tick();
    cast = 1'b0; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    expv = {1'b0, 8'h10, 8'h10, 4'd1, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL midsend_data: got %h want %h", obs, expv); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    expv = 24'h0;
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL midsend_reset: got %h want %h", obs, expv); end
    sel = 3'd2; cast = 1'b1;
    tick();
    cast = 1'b0; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL idle_cast_ignored: got %h want %h", obs, expv); end
    start = 1'b1;
    tick();
    start = 1'b0;
    sel = 3'd2; cast = 1'b1;
    tick();
    cast = 1'b0;
    expv = {1'b0, 8'h00, 8'h04, 4'd0, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL restart_cast: got %h want %h", obs, expv); end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_single_ballot();
    test_cancel_priority();
    test_timeout();
    test_full_election();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
